// File: rtl/diff_counter_pkg.sv
// diff_counter_pkg
//   Shared definitions for the two-button up/down counter:
//   - state_e    : controller states (RUN, LOCK)
//   - count_t    : signed internal count, legal range -DIFF_MAX..+DIFF_MAX
//   - DISP_CODE  : 4-bit display field for counts -3..+3
//   - disp_code(): maps a count to its display field
package diff_counter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam int DIFF_MAX = 3;

    typedef logic signed [2:0] count_t;

    // Indexed by count + DIFF_MAX: -3, -2, -1, 0, +1, +2, +3.
    // Negative counts use the 4-bit two's-complement pattern.
    localparam logic [3:0] DISP_CODE [0:6] = '{
        4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3
    };

    function automatic logic [3:0] disp_code(input count_t v);
        logic [2:0] idx;
        idx = 3'(int'(v) + DIFF_MAX);
        return DISP_CODE[idx];
    endfunction

endpackage

// File: rtl/diff_counter_button_conditioner.sv
// button_conditioner
//   Cleans up one raw active-low pushbutton: 2-flop synchronizer,
//   debouncer, and a one-cycle pulse on each accepted press.
//   Ports:
//     clk       system clock
//     rst_n     asynchronous active-low reset
//     btn_n_i   raw button, active-low, asynchronous, may bounce
//     press_o   registered one-cycle pulse on a filtered 1->0 transition
//   A press is only reported once the button has been seen stably released
//   after reset, so a button held through reset never produces an event.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [1:0]       vld_q;      // marks when sync_q holds real samples, not reset values
    logic             level_q,   level_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             armed_q,   armed_d;
    logic             press_q,   press_d;
    logic             sample;

    assign sample  = sync_q[1];
    assign press_o = press_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        level_d   = level_q;
        cnt_d     = cnt_q;
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        press_d   = 1'b0;

        if (vld_q[1]) begin
            if (sample != level_q) begin
                arm_cnt_d = '0;
                if (cnt_q == CNT_LAST) begin
                    level_d = sample;
                    cnt_d   = '0;
                    press_d = armed_q & ~sample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                // Any sample agreeing with the filtered level restarts the debounce.
                cnt_d = '0;
                // Arm only after a full debounce window of confirmed release.
                if (!armed_q && level_q) begin
                    if (arm_cnt_q == CNT_LAST) begin
                        armed_d = 1'b1;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            vld_q     <= 2'b00;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_n_i};
            vld_q     <= {vld_q[0], 1'b1};
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
        end
    end

endmodule

// File: rtl/diff_counter.sv
// diff_counter
//   Signed up/down counter driven by two debounced pushbuttons.
//   A press adds 1, B press subtracts 1; reaching +/-3 locks the counter
//   until clear. Outputs feed a 7-segment decoder.
//   Ports:
//     clk     system clock
//     rst_n   asynchronous active-low reset
//     btn_a   raw button A, active-low
//     btn_b   raw button B, active-low
//     clear   synchronous clear, active-high (priority over presses)
//     diff    4-bit display field (two's complement for negatives)
//     sinal   sign, 1 = negative
//     upd     one-cycle pulse when diff/sinal take a new value
//     locked  high while in LOCK
module diff_counter
    import diff_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       clear,
    output logic [3:0] diff,
    output logic       sinal,
    output logic       upd,
    output logic       locked
);

    logic press_a, press_b;
    logic a_only, b_only;

    state_e     state_q,  state_d;
    count_t     v_q,      v_d;
    logic [3:0] diff_q,   diff_d;
    logic       sinal_q,  sinal_d;
    logic       upd_q,    upd_d;
    logic       locked_q, locked_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (btn_a),
        .press_o (press_a)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (btn_b),
        .press_o (press_b)
    );

    // Simultaneous presses cancel out.
    assign a_only = press_a & ~press_b;
    assign b_only = press_b & ~press_a;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        upd_d   = 1'b0;

        if (clear) begin
            v_d     = '0;
            state_d = ST_RUN;
            upd_d   = (v_q != '0);
        end else if (state_q == ST_RUN && (a_only || b_only)) begin
            // In RUN |v| <= 2, so a single step never leaves -3..+3.
            v_d   = a_only ? v_q + count_t'(1) : v_q - count_t'(1);
            upd_d = 1'b1;
            if (v_d == count_t'(DIFF_MAX) || v_d == count_t'(-DIFF_MAX)) begin
                state_d = ST_LOCK;
            end
        end

        diff_d   = disp_code(v_d);
        sinal_d  = v_d[2];
        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            v_q      <= '0;
            diff_q   <= 4'h0;
            sinal_q  <= 1'b0;
            upd_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            diff_q   <= diff_d;
            sinal_q  <= sinal_d;
            upd_q    <= upd_d;
            locked_q <= locked_d;
        end
    end

    assign diff   = diff_q;
    assign sinal  = sinal_q;
    assign upd    = upd_q;
    assign locked = locked_q;

endmodule

// File: doc/diff_counter.md
DIFF_COUNTER -- requirements
Module: diff_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required before a button level is accepted; legal range 2..65535.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 btn_a  input  1  raw pushbutton A, active-low, asynchronous to clk, may bounce.
REQ-005 btn_b  input  1  raw pushbutton B, active-low, asynchronous to clk, may bounce.
REQ-006 clear  input  1  synchronous request, active-high; returns the count to 0 and the state to RUN.
REQ-007 diff  output  4  magnitude/two's-complement field for the 7-segment decoder.
REQ-008 sinal  output  1  sign for the 7-segment decoder; 1 = negative.
REQ-009 upd  output  1  single-cycle pulse marking the cycle diff/sinal take a new value.
REQ-010 locked  output  1  high while the FSM is in LOCK.

Function
REQ-011 Each button path SHALL have a 2-flop synchronizer, then a debouncer; the filtered level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples that differ from the current filtered level.
REQ-012 A press event SHALL be a 1->0 transition of the filtered level, lasting one cycle; releases generate no event.
REQ-013 The internal count v SHALL be signed, range -3..+3: an A-only event adds 1; a B-only event subtracts 1; simultaneous A and B events in the same cycle leave v unchanged and do not pulse upd.
REQ-014 Encoding SHALL be: v>=0 gives sinal=0, diff=v (0000..0011); v<0 gives sinal=1, diff=(16+v) mod 16, so -1=1111, -2=1110, -3=1101.
REQ-015 diff, sinal, upd and locked SHALL be registered; the new value appears the cycle after the press event, and upd is high in that same cycle.
REQ-016 The FSM SHALL have states RUN and LOCK only.
REQ-017 In RUN, an event that brings |v| to 3 SHALL update v and move the FSM to LOCK in the same clock edge.
REQ-018 In LOCK, all press events SHALL be ignored: no change to v and no upd pulse.
REQ-019 clear=1 in any state SHALL, on the next edge, set v=0 and the state to RUN; upd pulses only if v was nonzero; clear has priority over a press event in the same cycle.
REQ-020 Worst-case latency from a stable raw press to the output update SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-021 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no event; the debounce counter restarts on any mismatch.

Reset
REQ-022 While rst_n=0, all outputs SHALL be: diff=0000, sinal=0, upd=0, locked=0.
REQ-023 While rst_n=0, the FSM SHALL be in RUN, v=0, synchronizer and filtered levels=1 (released), and debounce counters=0.
REQ-024 Reset asserted mid-debounce or in LOCK SHALL discard the pending event; after reset release, a button still held SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (RUN, LOCK), DIFF_MAX=3, and the display codes for -3..+3.
REQ-026 A sub-module button_conditioner (synchronizer, debouncer, falling-edge pulse; parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.
REQ-027 diff/sinal SHALL connect directly to the existing 7-segment decoder ports of the same names.

Verification (bench DEBOUNCE_CYCLES=4)
REQ-028 Reset, then press A three times -> diff/sinal 0/0011 (sign/field), upd pulses 3 times, locked=1 after the third press; a fourth A press produces no change.
REQ-029 Press B twice from 0 -> 1/1111 then 1/1110; press A once -> 1/1111.
REQ-030 Raw A glitches low for 3 cycles, then 1 cycle high, repeated 5 times -> no upd, diff stays 0000.
REQ-031 A and B events in the same cycle at v=+1 -> no upd, output stays 0/0001.
REQ-032 In LOCK at v=-3 (1/1101), assert clear together with an A event -> next cycle 0/0000, upd=1, locked=0, A event ignored.
REQ-033 Hold A low, pulse rst_n low mid-debounce, keep A held -> no event; release then press A -> 0/0001 exactly 2+4+1 cycles after the press.
